// File: rtl/cube_scaled_seq_if.sv
// Handshake bundle for cube_scaled_seq: start/operand in, result/status out.
interface cube_scaled_seq_if #(
    parameter int W = 27
);
    logic         st;
    logic [W-1:0] ROOT;
    logic [W-1:0] BIN;
    logic         ovf;
    logic         busy;
    logic         ok;

    modport master (output st, ROOT, input BIN, ovf, busy, ok);
    modport slave  (input st, ROOT, output BIN, ovf, busy, ok);
endinterface

// File: rtl/cube_scaled_seq.sv
// Sequential BIN = floor(ROOT^3 / M): two shift-add multiplies, then a
// restoring divide by the constant M, all under one FSM.
module cube_scaled_seq #(
    parameter int          W = 27,
    parameter logic [49:0] M = 50'h38D7EA4C68000
) (
    input logic              clk,
    input logic              rst_n,
    cube_scaled_seq_if.slave bus
);
    localparam int P1W = 2 * W;
    localparam int P2W = 3 * W;
    localparam logic [5:0] CNT_LAST = 6'(W - 1);
    localparam logic [5:0] DIV_END  = 6'd32;

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, DIV, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   r;
    logic [P1W-1:0] p1;
    logic [P2W-1:0] p2;
    // Remainder stays below M < 2^50; the 51-bit value only exists as the trial.
    logic [49:0]    rem;
    logic [31:0]    q;
    logic [5:0]     cnt;
    logic [W-1:0]   bin_q;
    logic           ovf_q;

    logic [P1W-1:0] p1_add;
    logic [P2W-1:0] p2_nxt;
    logic [50:0]    trial;
    logic [49:0]    rem_nxt;
    logic           bit_in;
    logic           ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.st) state_nxt = MUL1;
            MUL1:    if (cnt == CNT_LAST) state_nxt = MUL2;
            MUL2:    if (cnt == CNT_LAST) state_nxt = DIV;
            DIV:     if (cnt == DIV_END) state_nxt = DONE;
            DONE:    state_nxt = bus.st ? MUL1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        p1_add  = r[cnt[4:0]] ? ({{W{1'b0}}, r} << cnt) : '0;
        p2_nxt  = p2 + (r[cnt[4:0]] ? ({{W{1'b0}}, p1} << cnt) : '0);
        bit_in  = p2[5'd31 - cnt[4:0]];
        trial   = {rem, bit_in};
        ge      = trial >= {1'b0, M};
        rem_nxt = 50'(ge ? (trial - {1'b0, M}) : trial);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r     <= '0;
            p1    <= '0;
            p2    <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            bin_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.st) begin
                    r   <= bus.ROOT;
                    p1  <= '0;
                    p2  <= '0;
                    rem <= '0;
                    q   <= '0;
                    cnt <= '0;
                end
                MUL1: begin
                    p1  <= p1 + p1_add;
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 6'd1;
                end
                MUL2: begin
                    p2 <= p2_nxt;
                    // Upper 49 dividend bits are already below M, so they seed the remainder.
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        rem <= {1'b0, p2_nxt[P2W-1:32]};
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    if (cnt == DIV_END) begin
                        bin_q <= (|q[31:W]) ? {W{1'b1}} : q[W-1:0];
                        ovf_q <= |q[31:W];
                    end else begin
                        rem <= rem_nxt;
                        q   <= {q[30:0], ge};
                        cnt <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.BIN  = bin_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state == MUL1) || (state == MUL2) || (state == DIV);
    assign bus.ok   = (state == DONE);
endmodule

// File: tb/tb_cube_scaled_seq.sv
// Bench for cube_scaled_seq: cycle-timed reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_cube_scaled_seq;
    localparam int W = 27;
    localparam logic [W-1:0] SAT = {W{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cube_scaled_seq_if #(.W(W)) bus ();
    cube_scaled_seq #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // {ovf, BIN} straight from the arithmetic definition.
    function automatic logic [W:0] ref_fn(input logic [W-1:0] r);
        logic [127:0] c, qq;
        c  = 128'(r) * 128'(r) * 128'(r);
        qq = c / 128'd1000000000000000;
        if (qq >= (128'd1 << W)) return {1'b1, SAT};
        return {1'b0, qq[W-1:0]};
    endfunction

    // Model: age counts edges since the accepting edge; result lands at age 87.
    logic         m_run = 1'b0;
    int           m_age = 0;
    logic [W-1:0] m_root = '0;
    logic [W-1:0] m_bin = '0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_age <= 0;
            m_bin <= '0;
            m_ovf <= 1'b0;
        end else if (!m_run || m_age == 87) begin
            if (bus.st) begin
                m_run  <= 1'b1;
                m_age  <= 0;
                m_root <= bus.ROOT;
            end else begin
                m_run <= 1'b0;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age == 86) {m_ovf, m_bin} <= ref_fn(m_root);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cyc_busy", bus.busy, m_run && m_age < 87);
            check("cyc_ok",   bus.ok,   m_run && m_age == 87);
            check("cyc_bin",  bus.BIN,  m_bin);
            check("cyc_ovf",  bus.ovf,  m_ovf);
        end
    end

    task automatic wait_ok(output int n);
        n = 0;
        while (!bus.ok && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] root, input logic [W-1:0] exp_bin,
                          input logic exp_ovf, input string tag);
        int n;
        @(negedge clk);
        bus.ROOT = root;
        bus.st   = 1'b1;
        @(negedge clk);
        bus.st   = 1'b0;
        bus.ROOT = W'($urandom);
        wait_ok(n);
        check({tag, "_lat"}, n, 87);
        check({tag, "_bin"}, bus.BIN, exp_bin);
        check({tag, "_ovf"}, bus.ovf, exp_ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, oks, ok_at;
        bus.st   = 1'b0;
        bus.ROOT = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_ok",   bus.ok,   0);
        check("rst_bin",  bus.BIN,  0);
        check("rst_ovf",  bus.ovf,  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("ref_unit",  ref_fn(27'd100000),   {1'b0, 27'd1});
        check("ref_floor", ref_fn(27'd4641588),  {1'b0, 27'd99999});
        check("ref_pow2",  ref_fn(27'd51200000), {1'b1, SAT});
        check("ref_8",     ref_fn(27'd200000),   {1'b0, 27'd8});

        run_op(27'd100000,   27'd1,     1'b0, "unit");
        run_op(27'd0,        27'd0,     1'b0, "zero");
        run_op(27'd4641588,  27'd99999, 1'b0, "floor");
        run_op(27'd51200000, SAT,       1'b1, "ovf_pow2");
        run_op(SAT,          SAT,       1'b1, "ovf_max");

        // Stray start strobes while busy are ignored.
        @(negedge clk);
        bus.ROOT = 27'd200000;
        bus.st   = 1'b1;
        @(negedge clk);
        bus.st   = 1'b0;
        bus.ROOT = 27'd300000;
        oks = 0;
        ok_at = 0;
        for (int i = 1; i <= 100; i++) begin
            bus.st = (i == 10 || i == 50);
            @(negedge clk);
            if (bus.ok) begin
                oks++;
                ok_at = i;
            end
            if (i == 87) check("ign_bin", bus.BIN, 27'd8);
        end
        bus.st = 1'b0;
        check("ign_count", oks, 1);
        check("ign_lat", ok_at, 87);

        // st held through DONE restarts with the ROOT present at that time.
        @(negedge clk);
        bus.ROOT = 27'd300000;
        bus.st   = 1'b1;
        @(negedge clk);
        bus.ROOT = 27'd400000;
        wait_ok(n);
        check("b2b1_lat", n, 87);
        check("b2b1_bin", bus.BIN, 27'd27);
        @(negedge clk);
        bus.st = 1'b0;
        check("b2b_restart_busy", bus.busy, 1);
        wait_ok(n);
        check("b2b2_lat", n, 87);
        check("b2b2_bin", bus.BIN, 27'd64);

        // Reset in the middle of the second multiply.
        @(negedge clk);
        bus.ROOT = 27'd100000;
        bus.st   = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ok",   bus.ok,   0);
        check("mid_rst_bin",  bus.BIN,  0);
        check("mid_rst_ovf",  bus.ovf,  0);
        @(negedge clk);
        rst_n = 1'b1;
        oks = 0;
        repeat (120) begin
            @(negedge clk);
            if (bus.ok) oks++;
        end
        check("mid_rst_no_ok", oks, 0);
        check("mid_rst_idle_bin", bus.BIN, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
